// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch sequencer.
//
// Walks IDLE -> REQ -> WAIT -> VALID -> EXEC for each instruction. It issues
// one memory read in REQ, latches the returned word as WAIT exits, and offers
// that word to decode in VALID. In EXEC it waits until execute resolves the
// instruction, then loads the PC that the branch stage computed.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   next_pc, pc_update    resolved next PC from the branch/execute stages
//   halt                  stop after the current instruction
//   pc_current            architectural PC, stable from REQ through EXEC
//   imem_en, imem_addr    instruction memory read request (addr == pc_current)
//   imem_rdata            read data, valid one cycle after imem_en
//   instr, instr_valid    registered instruction offered to decode
//   instr_ready           decode acceptance
//   instr_count           (FETCH_COUNT_EN only) count of accepted instructions
//
// Optional build macro: FETCH_COUNT_EN adds the instr_count output.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  next_pc,
    input  logic        pc_update,
    input  logic        halt,
    output logic [9:0]  pc_current,
    output logic        imem_en,
    output logic [9:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, EXEC} state_t;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        imem_en_q, imem_en_d;
    logic        instr_valid_q, instr_valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE:  if (!halt) state_d = REQ;
            REQ:   state_d = WAIT;
            WAIT: begin
                // Memory data is valid during WAIT; latch it on the way out.
                state_d = VALID;
                instr_d = imem_rdata;
            end
            VALID: if (instr_ready) state_d = EXEC;
            EXEC: begin
                // Only EXEC accepts a PC update. halt is looked at on this edge
                // too, so a simultaneous halt still loads the new PC.
                if (pc_update) begin
                    pc_d    = next_pc;
                    state_d = halt ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        // The outputs are registered and decoded from the next state, so they
        // line up exactly with the state they belong to.
        imem_en_d     = (state_d == REQ);
        instr_valid_d = (state_d == VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            imem_en_q     <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_en_q     <= imem_en_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign pc_current  = pc_q;
    assign imem_addr   = pc_q;
    assign imem_en     = imem_en_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

`ifdef FETCH_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts decode handshakes; it wraps naturally at 16 bits.
    always_comb cnt_d = cnt_q + {15'd0, instr_valid_q & instr_ready};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`endif

endmodule
